// File: rtl/sdma_sched_pkg.sv
`default_nettype none
// sdma_sched_pkg: shared state encoding and default sizing for the SDMA request scheduler.
// Rev 1.0
package sdma_sched_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_TO_WIDTH = 10;
  localparam int DEF_TO_LIMIT = 'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/sdma_req_sched_rr_arbiter.sv
`default_nettype none
// rr_arbiter: one-hot round-robin picker, searching upward from the slot after the last winner.
// Rev 1.0
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdma_req_sched.sv
`default_nettype none
// sdma_req_sched: grants the single SDMA engine to one FIFO channel at a time, with timeout abort.
// Rev 1.0
module sdma_req_sched
  import sdma_sched_pkg::*;
#(
  parameter int                NUM_CH   = DEF_NUM_CH,
  parameter int                TO_WIDTH = DEF_TO_WIDTH,
  parameter logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(DEF_TO_LIMIT)
) (
  input  logic              WB_CLK,
  input  logic              WB_RSTn,
  input  logic [NUM_CH-1:0] Ch_Req_i,
  input  logic [NUM_CH-1:0] Ch_En_i,
  output logic [NUM_CH-1:0] SDMA_Req_o,
  input  logic [NUM_CH-1:0] SDMA_Active_i,
  input  logic [NUM_CH-1:0] SDMA_Done_i,
  output logic [NUM_CH-1:0] Ch_Grant_o,
  output logic [NUM_CH-1:0] Ch_Done_o,
  output logic [NUM_CH-1:0] TO_Sts_o,
  input  logic [NUM_CH-1:0] TO_Clr_i,
  output logic              Busy_o,
  output logic              Interrupt_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sched_state_e      state, state_nxt;
  logic [NUM_CH-1:0] grant, grant_nxt;
  logic [NUM_CH-1:0] sdma_req, sdma_req_nxt;
  logic [NUM_CH-1:0] ch_done, ch_done_nxt;
  logic [NUM_CH-1:0] to_sts, to_sts_nxt, to_set;
  logic [IDX_W-1:0]  last_idx, last_idx_nxt;
  logic [IDX_W-1:0]  gnt_idx, gnt_idx_nxt;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_nxt, to_cnt_inc;
  logic              busy, irq;

  logic [NUM_CH-1:0] eligible, arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              hit_active, hit_done, timeout;

  assign eligible   = Ch_Req_i & Ch_En_i & ~to_sts;
  // Only the owning channel's handshake lines matter.
  assign hit_active = |(SDMA_Active_i & grant);
  assign hit_done   = |(SDMA_Done_i & grant);
  assign to_cnt_inc = (to_cnt == TO_LIMIT) ? to_cnt : to_cnt + TO_WIDTH'(1);
  assign timeout    = (to_cnt_inc == TO_LIMIT);

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (eligible),
    .last    (last_idx),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    sdma_req_nxt = sdma_req;
    ch_done_nxt  = '0;
    to_set       = '0;
    to_cnt_nxt   = to_cnt;
    last_idx_nxt = last_idx;
    gnt_idx_nxt  = gnt_idx;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          state_nxt    = ST_REQ;
          grant_nxt    = arb_gnt;
          sdma_req_nxt = arb_gnt;
          gnt_idx_nxt  = arb_idx;
          to_cnt_nxt   = '0;
        end
      end
      ST_REQ: begin
        to_cnt_nxt = to_cnt_inc;
        if (hit_active && hit_done) begin
          state_nxt    = ST_DONE;
          sdma_req_nxt = '0;
          ch_done_nxt  = grant;
        end else if (timeout) begin
          state_nxt    = ST_ABORT;
          sdma_req_nxt = '0;
          to_set       = grant;
        end else if (hit_active) begin
          state_nxt    = ST_XFER;
          sdma_req_nxt = '0;
        end
      end
      ST_XFER: begin
        to_cnt_nxt = to_cnt_inc;
        // A completion arriving on the timeout cycle still counts as success.
        if (hit_done) begin
          state_nxt   = ST_DONE;
          ch_done_nxt = grant;
        end else if (timeout) begin
          state_nxt = ST_ABORT;
          to_set    = grant;
        end
      end
      ST_DONE, ST_ABORT: begin
        state_nxt    = ST_IDLE;
        grant_nxt    = '0;
        sdma_req_nxt = '0;
        last_idx_nxt = gnt_idx;
      end
      default: begin
        state_nxt    = ST_IDLE;
        grant_nxt    = '0;
        sdma_req_nxt = '0;
      end
    endcase
    to_sts_nxt = (to_sts & ~TO_Clr_i) | to_set;
  end

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state    <= ST_IDLE;
      grant    <= '0;
      sdma_req <= '0;
      ch_done  <= '0;
      to_sts   <= '0;
      to_cnt   <= '0;
      last_idx <= IDX_W'(NUM_CH - 1);
      gnt_idx  <= '0;
      busy     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sdma_req <= sdma_req_nxt;
      ch_done  <= ch_done_nxt;
      to_sts   <= to_sts_nxt;
      to_cnt   <= to_cnt_nxt;
      last_idx <= last_idx_nxt;
      gnt_idx  <= gnt_idx_nxt;
      busy     <= (state_nxt != ST_IDLE);
      irq      <= |to_sts_nxt;
    end
  end

  assign SDMA_Req_o  = sdma_req;
  assign Ch_Grant_o  = grant;
  assign Ch_Done_o   = ch_done;
  assign TO_Sts_o    = to_sts;
  assign Busy_o      = busy;
  assign Interrupt_o = irq;

endmodule
`default_nettype wire
